// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Constants shared by the 2x2 max-pooling datapath.
//                - c_DEFAULT_DATA_WIDTH : default unsigned pixel width
//                - c_POOL_WIN           : pooling window edge length (2)
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_POOL_WIN           = 2;

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_max2.sv
`default_nettype none
// ============================================================================
//  Module      : pool_max2
//  Description : Combinational unsigned two-input maximum.
//  Ports       : i_a, i_b  - operands (DATA_WIDTH bits, unsigned)
//                o_max     - larger of the two operands
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_max2
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
)(
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_max
);

    // On equality both operands are identical, so either choice is correct.
    assign o_max = (i_a >= i_b) ? i_a : i_b;

endmodule : pool_max2
`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2
//  Description : Streaming 2x2 max pooling over a raster-ordered feature map.
//                Even columns are parked in a horizontal register; odd
//                columns produce the horizontal pair maximum. On even rows
//                that maximum goes into a half-width line buffer, on odd
//                rows it is combined with the buffered value to form the
//                window result, which is held in a one-entry output register.
//  Ports       : clk        - clock, rising edge
//                nrst       - asynchronous active-low reset
//                clear      - synchronous restart of the frame position
//                in_valid   - upstream pixel valid
//                in_ready   - block accepts a pixel this cycle
//                in_data    - pixel (DATA_WIDTH bits, unsigned)
//                out_valid  - pooled result valid
//                out_ready  - downstream accepts the result
//                out_data   - 2x2 window maximum
//                out_last   - final pooled result of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_2x2
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ROW_WIDTH  = 16,
    parameter int FRAME_ROWS = 16
)(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int c_COL_W    = $clog2(ROW_WIDTH);
    localparam int c_ROW_W    = $clog2(FRAME_ROWS);
    localparam int c_LB_DEPTH = ROW_WIDTH / c_POOL_WIN;
    localparam int c_LB_AW    = (c_COL_W > 1) ? (c_COL_W - 1) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ROW_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(FRAME_ROWS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic [DATA_WIDTH-1:0] r_h;
    logic [DATA_WIDTH-1:0] r_linebuf [c_LB_DEPTH];
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic                  w_take;
    logic                  w_col_odd;
    logic                  w_row_odd;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_lb_write;
    logic                  w_result_load;
    logic                  w_out_fire;
    logic [c_LB_AW-1:0]    w_lb_addr;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_vmax;
    logic [DATA_WIDTH-1:0] w_lb_rdata;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // clear wins over a same-cycle input transfer: the pixel is dropped.
    assign w_take = in_valid && in_ready && !clear;

    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    assign w_lb_write    = w_take && w_col_odd && !w_row_odd;
    assign w_result_load = w_take && w_col_odd &&  w_row_odd;

    // Line-buffer slot is the column pair index; a 2-pixel-wide map has a
    // single slot and no address bits to take from the column counter.
    generate
        if (c_COL_W > 1) begin : g_addr_wide
            assign w_lb_addr = r_col[c_COL_W-1:1];
        end else begin : g_addr_single
            assign w_lb_addr = '0;
        end
    endgenerate

    assign w_lb_rdata = r_linebuf[w_lb_addr];

    // ------------------------------------------------------------------------
    // Datapath: horizontal pair max, then vertical max against the line buffer
    // ------------------------------------------------------------------------
    pool_max2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hmax (
        .i_a   (r_h),
        .i_b   (in_data),
        .o_max (w_hmax)
    );

    pool_max2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_vmax (
        .i_a   (w_lb_rdata),
        .i_b   (w_hmax),
        .o_max (w_vmax)
    );

    // ------------------------------------------------------------------------
    // Counters, horizontal register and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (clear) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_take) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : (r_row + 1'b1);
                end else begin
                    r_col <= r_col + 1'b1;
                end

                if (!w_col_odd) begin
                    r_h <= in_data;
                end
            end

            // A new result overrides the drain of the previous one.
            if (w_result_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_vmax;
                r_out_last  <= w_row_last && w_col_last;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Line buffer carries no reset: every slot is rewritten on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (w_lb_write) begin
            r_linebuf[w_lb_addr] <= w_hmax;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : max_pool_2x2
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_pool_2x2
//  Description : Self-checking bench for max_pool_2x2 on a 4x4 feature map.
//                Expected results come from a window-maximum model computed
//                directly from whole frames of pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_2x2;

    localparam int c_DW   = 8;
    localparam int c_COLS = 4;
    localparam int c_ROWS = 4;
    localparam int c_NPIX = c_COLS * c_ROWS;

    logic            clk;
    logic            nrst;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [c_DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [c_DW-1:0] out_data;
    logic            out_last;

    int unsigned pix_q [$];
    int unsigned exp_d [$];
    bit          exp_l [$];
    int          n_cmp;
    int          n_fail;

    max_pool_2x2 #(
        .DATA_WIDTH (c_DW),
        .ROW_WIDTH  (c_COLS),
        .FRAME_ROWS (c_ROWS)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each 2x2 window's maximum in raster order of windows; the
    // final window of the frame is flagged as last.
    task automatic push_frame(input int unsigned px [c_NPIX]);
        for (int wr = 0; wr < c_ROWS / 2; wr++) begin
            for (int wc = 0; wc < c_COLS / 2; wc++) begin
                int unsigned m;
                int          base;
                base = (2 * wr) * c_COLS + 2 * wc;
                m = 0;
                foreach (px[k]) begin
                    if ((k == base || k == base + 1 || k == base + c_COLS || k == base + c_COLS + 1)
                        && px[k] > m)
                        m = px[k];
                end
                exp_d.push_back(m);
                exp_l.push_back((wr == c_ROWS / 2 - 1) && (wc == c_COLS / 2 - 1));
            end
        end
        foreach (px[k]) pix_q.push_back(px[k]);
    endtask

    task automatic push_ramp();
        int unsigned px [c_NPIX];
        foreach (px[k]) px[k] = k;
        push_frame(px);
    endtask

    task automatic push_random();
        int unsigned px [c_NPIX];
        foreach (px[k]) px[k] = $urandom_range(0, 255);
        push_frame(px);
    endtask

    // Streams every queued pixel and checks every output transfer against
    // the model; optional random valid/ready gaps.
    task automatic run(input bit rnd, input int budget);
        int cyc;
        cyc = 0;
        while ((pix_q.size() > 0 || exp_d.size() > 0) && cyc < budget) begin
            in_valid  = (pix_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            in_data   = (pix_q.size() > 0) ? c_DW'(pix_q[0]) : '0;
            out_ready = !rnd || ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    check("out_data", 32'(out_data), exp_d.pop_front());
                    check("out_last", 32'(out_last), 32'(exp_l.pop_front()));
                end
            end
            if (in_valid && in_ready) void'(pix_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_drained", 32'(pix_q.size() + exp_d.size()), 32'd0);
        pix_q.delete();
        exp_d.delete();
        exp_l.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Feeds n pixels one per cycle with out_ready held low.
    task automatic feed_stalled(input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = c_DW'(pix_q[0]);
            #1;
            if (in_ready) void'(pix_q.pop_front());
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        nrst      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Ramp 0..15 with no backpressure: 5, 7, 13, 15
        push_ramp();
        run(1'b0, 200);

        // Downstream stalls from the first result onward
        push_ramp();
        feed_stalled(6);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = c_DW'(pix_q[0]);
            #1;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data",  32'(out_data),  32'd5);
            check("stall_out_last",  32'(out_last),  32'd0);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        check("stall_pixels_left", 32'(pix_q.size()), 32'(c_NPIX - 6));
        run(1'b0, 200);

        // Boundary values: {255,0;0,254} and an all-equal 9 window
        begin
            int unsigned px [c_NPIX];
            foreach (px[k]) px[k] = $urandom_range(0, 255);
            px[0] = 255; px[1] = 0;  px[4] = 0;  px[5] = 254;
            px[2] = 9;   px[3] = 9;  px[6] = 9;  px[7] = 9;
            push_frame(px);
            check("model_win0", exp_d[0], 32'd255);
            check("model_win1", exp_d[1], 32'd9);
            run(1'b0, 200);
        end

        // clear after 6 pixels, asserted alongside a pixel offer
        push_ramp();
        feed_stalled(6);
        pix_q.delete();
        exp_d.delete();
        exp_l.delete();
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd99;
        out_ready = 1'b1;
        #1;
        check("clear_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clear_out_valid", 32'(out_valid), 32'd0);
        push_ramp();
        run(1'b0, 200);

        // Asynchronous reset mid-frame with a result pending
        push_ramp();
        feed_stalled(6);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        nrst = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data",  32'(out_data),  32'd0);
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #2;
        nrst = 1'b1;
        pix_q.delete();
        exp_d.delete();
        exp_l.delete();
        @(posedge clk); #1;
        push_random();
        run(1'b0, 200);

        // Two back-to-back random frames with random handshake gaps
        for (int rep = 0; rep < 3; rep++) begin
            push_random();
            push_random();
            run(1'b1, 2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_max_pool_2x2
`default_nettype wire

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the unsigned pixel width.
REQ-002 The block SHALL have parameter ROW_WIDTH, default 16, which is the input feature-map width in pixels (even, >= 2).
REQ-003 The block SHALL have parameter FRAME_ROWS, default 16, which is the input feature-map height in rows (even, >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1 bit: the reset, asynchronous, active-low.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous restart of frame position.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream pixel is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH bits: the pixel, in raster order (row-major).
REQ-010 The block SHALL have port out_valid, output, 1 bit: the pooled result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream (pooling register file write side) accepts the result.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH bits: the 2x2 window maximum.
REQ-013 The block SHALL have port out_last, output, 1 bit: marks the final pooled result of a frame.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be combinational: !out_valid || out_ready (one-entry output register, full-throughput when never stalled).
REQ-016 On an accepted pixel, the column counter SHALL increment and wrap from ROW_WIDTH-1 to 0; on wrap, the row counter SHALL increment and wrap from FRAME_ROWS-1 to 0.
REQ-017 For an even column, the pixel SHALL be held in a horizontal register h_reg.
REQ-018 For an odd column, hmax = max(h_reg, in_data), using unsigned compare; on equality, either operand is acceptable since the values are identical.
REQ-019 For an even row at an odd column, hmax SHALL be written to line buffer entry col/2, which has ROW_WIDTH/2 entries of DATA_WIDTH bits.
REQ-020 For an odd row at an odd column, out_data SHALL load max(linebuf[col/2], hmax) and out_valid SHALL be set on the following edge, giving 1-cycle latency from the accepting edge.
REQ-021 out_last SHALL load 1 with that result iff row == FRAME_ROWS-1 and col == ROW_WIDTH-1; otherwise it SHALL load 0.
REQ-022 out_valid SHALL clear after an output transfer unless a new result loads on the same edge; a simultaneous transfer and load SHALL leave out_valid at 1 with the new data.
REQ-023 out_data and out_last SHALL remain stable while out_valid && !out_ready.
REQ-024 clear SHALL take priority over an input transfer on the same cycle: counters reset to 0, out_valid reset to 0, and the pixel is not consumed into state; in_ready is unaffected.
REQ-025 Results SHALL total (ROW_WIDTH/2)*(FRAME_ROWS/2) per frame, and frames SHALL follow back-to-back without gaps.

Reset
REQ-026 On nrst low, out_valid, out_last, and out_data SHALL be 0, col/row counters SHALL be 0, h_reg SHALL be 0, and in_ready SHALL therefore be 1.
REQ-027 The line buffer SHALL not be reset, since every entry is written on an even row before it is read.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is row 0, col 0.

Structure
REQ-029 Shared package pool_pkg SHALL hold the DATA_WIDTH default and the pool window size constant (2).
REQ-030 A single sub-module pool_max2 (combinational unsigned 2-input max) SHALL be instantiated twice: once for horizontal and once for vertical.
REQ-031 Counter widths SHALL be $clog2(ROW_WIDTH) and $clog2(FRAME_ROWS); the line-buffer address SHALL be col[msb:1].

Verification
REQ-032 The bench SHALL cover: with ROW_WIDTH=4, FRAME_ROWS=4, out_ready=1, stream pixels 0..15 -> outputs 5, 7, 13, 15; out_last only with 15.
REQ-033 The bench SHALL cover: the same stream with out_ready=0 from the first result -> out_valid held at 5, in_ready=0, no further pixels taken; out_ready=1 resumes with 7, 13, 15, and none are lost.
REQ-034 The bench SHALL cover: window {255, 0, 0, 254} and a window of all-equal 9 -> outputs 255 and 9.
REQ-035 The bench SHALL cover: clear after 6 pixels, then pixels 0..15 -> outputs 5, 7, 13, 15 with no stale result.
REQ-036 The bench SHALL cover: nrst pulsed low mid-frame while out_valid=1 -> out_valid=0 immediately, and the next frame is pooled correctly.
REQ-037 The bench SHALL cover: two back-to-back frames with random in_valid/out_ready gaps -> 8 results matching the reference max model, with out_last on the 4th and 8th.
